// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module      : pc_sequencer_if
// Description : Fetch/decode/redirect bundle of the program-counter sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_valid;
    logic             id_ready;
    logic             br_en;
    logic [WIDTH-1:0] br_base;
    logic [WIDTH-1:0] br_offset;
    logic             jmp_en;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] pc_out;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, pc_out,
        input  imem_ack, imem_data, id_ready, br_en, br_base, br_offset,
               jmp_en, jmp_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, pc_out,
        output imem_ack, imem_data, id_ready, br_en, br_base, br_offset,
               jmp_en, jmp_target
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Owns the PC; sequences fetch requests, issue to decode and
//               branch/jump redirects.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] STEP     = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    pc_sequencer_if.master bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_ISSUE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] instr_q,    instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             pend_q,     pend_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic             redir_vld;
    logic [WIDTH-1:0] redir_tgt;

    // Jump outranks branch; the adder wraps modulo 2^WIDTH.
    assign redir_vld = bus.jmp_en | bus.br_en;
    assign redir_tgt = bus.jmp_en ? bus.jmp_target : (bus.br_base + bus.br_offset);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            c_IDLE: begin
                state_d = c_FETCH;
            end
            c_FETCH: begin
                if (bus.imem_ack) begin
                    // A redirect arriving with the ack is newer than any pending one.
                    if (redir_vld) begin
                        pc_d   = redir_tgt;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d    = bus.imem_data;
                        instr_pc_d = pc_q;
                        state_d    = c_ISSUE;
                    end
                end else if (redir_vld) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            c_ISSUE: begin
                if (redir_vld) begin
                    pc_d    = redir_tgt;
                    state_d = c_FETCH;
                end else if (bus.id_ready) begin
                    pc_d    = instr_pc_q + STEP;
                    state_d = c_FETCH;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == c_FETCH);
        bus.instr_valid = (state_q == c_ISSUE);
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc_out    = pc_q;
    assign bus.instr     = instr_q;
    assign bus.instr_pc  = instr_pc_q;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences every PC update: reset vector, sequential increment, relative branch, absolute jump and stall. It sits between the execute stage, which supplies redirect requests, and the instruction memory. It issues one request/acknowledge fetch per instruction and hands each fetched word to decode through a valid/ready handshake. The next-PC adder computes modulo 2^WIDTH.

## Interface
Parameters:
- WIDTH, 32: PC and instruction width.
- RESET_PC, 0: PC loaded on reset.
- STEP, 1: sequential increment (word-addressed memory).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  WIDTH  fetch address; equals pc_out while imem_req=1.
- imem_ack  input  1  memory has driven imem_data this cycle.
- imem_data  input  WIDTH  fetched instruction word.
- instr  output  WIDTH  instruction presented to decode.
- instr_pc  output  WIDTH  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- id_ready  input  1  decode accepts instr this cycle; 0 = stall.
- br_en  input  1  relative branch request.
- br_base  input  WIDTH  PC of branching instruction.
- br_offset  input  WIDTH  two's-complement offset.
- jmp_en  input  1  absolute jump request.
- jmp_target  input  WIDTH  jump destination.
- pc_out  output  WIDTH  current PC register.

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE: entered only from reset. No request is issued. Next state is FETCH unconditionally.
- FETCH: imem_req=1 and imem_addr=pc_out. The request is held until imem_ack=1 and is never withdrawn early.
  - On ack with no pending redirect: capture imem_data into instr and pc_out into instr_pc, then go to ISSUE.
  - On ack with a redirect pending, or a redirect arriving in the same cycle: discard the data, load pc_out with the redirect target, clear pending, and stay in FETCH. The new address is driven next cycle.
- ISSUE: instr_valid=1, imem_req=0. Priority order:
  - Redirect arriving (with or without id_ready): pc_out is loaded with the redirect target and the state goes to FETCH. If id_ready=1 in that cycle the instruction counts as consumed; otherwise it is dropped.
  - id_ready=1 with no redirect: pc_out is loaded with instr_pc+STEP and the state goes to FETCH.
  - id_ready=0: hold state. instr, instr_pc and instr_valid stay stable.
- Redirect target:
  - jmp_en=1 gives jmp_target; jmp_en has priority over br_en.
  - Otherwise br_en=1 gives br_base+br_offset, truncated to WIDTH bits with wrap-around and no overflow flag.
- Pending redirect: one register, set by a redirect arriving in FETCH without ack. A newer redirect before ack overwrites it, so the latest request wins. It is cleared on use or on reset.
- PC arithmetic: all additions are modulo 2^WIDTH. The all-ones PC plus STEP wraps to STEP-1.

## Timing
- Reset, asynchronous assertion: state=IDLE, pc_out=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, pending cleared. Outputs change without a clock edge.
- Cycle 0 is the first edge with rst_n=1: IDLE goes to FETCH. imem_req rises in cycle 1.
- Ack may arrive in the first request cycle. instr_valid rises the cycle after the ack edge.
- Minimum cadence is 2 cycles per instruction (FETCH + ISSUE) with imem_ack tied high and id_ready=1.
- Redirect inputs are sampled on the clock edge only in FETCH and ISSUE. In IDLE they are ignored.
- Redirect-to-new-fetch latency is 1 cycle from ISSUE. From FETCH it is 1 cycle after ack.
- Reset asserted mid-fetch: imem_req drops immediately and the outstanding ack is ignored. The memory must tolerate an abandoned request.

## Test plan
- Reset, then imem_ack tied 1, imem_data=addr, id_ready=1, RESET_PC=0: instr_pc sequence is 0,1,2,3 with instr_valid high every other cycle, starting cycle 2.
- Stall: id_ready=0 for 5 cycles while instr_pc=2: instr_valid stays 1 and instr stays 2, imem_req stays 0. Release gives next fetch at 3.
- Branch in ISSUE with br_base=4, br_offset=0xFFFFFFFE: the next imem_addr is 2. If id_ready=0 in that cycle, the held instruction is dropped.
- Redirect in FETCH with ack delayed 3 cycles: jmp_target=0x40, then br_en (0x10+0x8) 1 cycle later. The acked data is discarded and the next fetch is 0x18. Simultaneous jmp_en and br_en in another case gives jmp_target.
- Wrap: pc_out=0xFFFFFFFF, sequential advance gives next imem_addr=0x00000000.
- Async reset asserted mid-FETCH: imem_req=0 and pc_out=RESET_PC before the next clock edge. Fetch restarts at RESET_PC in cycle 1 after release.
